// File: rtl/sys_arr_2x2.sv
// 2x2 weight-stationary systolic array of 8-bit unsigned MAC elements.
// Data and active move right along rows; sums, weights and write enables move down columns.
module sys_arr_2x2 (
    input  logic        clk,
    input  logic        reset,
    input  logic        active,
    input  logic [15:0] datain,
    input  logic [15:0] win,
    input  logic [31:0] sumin,
    input  logic [1:0]  wwrite,
    output logic [15:0] maccout1,
    output logic [15:0] maccout2,
    output logic [7:0]  wout1,
    output logic [7:0]  wout2,
    output logic        wwriteout1,
    output logic        wwriteout2,
    output logic        activeout1,
    output logic        activeout2,
    output logic [7:0]  dataout1,
    output logic [7:0]  dataout2
);

    logic [7:0]  pe_data   [2][2];
    logic        pe_active [2][2];
    logic [15:0] pe_sum    [2][2];
    logic [7:0]  pe_wpass  [2][2];
    logic        pe_wwrite [2][2];

    genvar gi, gj;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_row
            for (gj = 0; gj < 2; gj++) begin : g_col
                logic [7:0]  data_in;
                logic [7:0]  win_in;
                logic        active_in;
                logic        wwrite_in;
                logic [15:0] sum_in;
                logic [15:0] product;
                logic [15:0] sum_next;

                logic [7:0]  w_reg;
                logic [7:0]  data_reg;
                logic [7:0]  wpass_reg;
                logic        active_reg;
                logic        wwrite_reg;
                logic [15:0] sum_reg;

                if (gj == 0) begin : g_data_edge
                    assign data_in = datain[gi*8 +: 8];
                end else begin : g_data_inner
                    assign data_in = pe_data[gi][gj-1];
                end

                // Column 0 of row 1 takes active from PE(0,0), matching the caller's row-1 skew.
                if (gi == 0 && gj == 0) begin : g_act_port
                    assign active_in = active;
                end else if (gj == 0) begin : g_act_down
                    assign active_in = pe_active[0][0];
                end else begin : g_act_left
                    assign active_in = pe_active[gi][gj-1];
                end

                if (gi == 0) begin : g_col_edge
                    assign sum_in    = sumin[gj*16 +: 16];
                    assign win_in    = win[gj*8 +: 8];
                    assign wwrite_in = wwrite[gj];
                end else begin : g_col_inner
                    assign sum_in    = pe_sum[gi-1][gj];
                    assign win_in    = pe_wpass[gi-1][gj];
                    assign wwrite_in = pe_wwrite[gi-1][gj];
                end

                // The MAC uses the weight held before this edge, even when a write lands now.
                assign product  = {8'd0, data_in} * {8'd0, w_reg};
                assign sum_next = sum_in + product;

                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        w_reg      <= '0;
                        data_reg   <= '0;
                        wpass_reg  <= '0;
                        active_reg <= 1'b0;
                        wwrite_reg <= 1'b0;
                        sum_reg    <= '0;
                    end else begin
                        wpass_reg  <= win_in;
                        wwrite_reg <= wwrite_in;
                        data_reg   <= data_in;
                        active_reg <= active_in;
                        if (wwrite_in) begin
                            w_reg <= win_in;
                        end
                        if (active_in) begin
                            sum_reg <= sum_next;
                        end
                    end
                end

                assign pe_data[gi][gj]   = data_reg;
                assign pe_active[gi][gj] = active_reg;
                assign pe_sum[gi][gj]    = sum_reg;
                assign pe_wpass[gi][gj]  = wpass_reg;
                assign pe_wwrite[gi][gj] = wwrite_reg;
            end
        end
    endgenerate

    assign maccout1   = pe_sum[1][0];
    assign maccout2   = pe_sum[1][1];
    assign wout1      = pe_wpass[1][0];
    assign wout2      = pe_wpass[1][1];
    assign wwriteout1 = pe_wwrite[1][0];
    assign wwriteout2 = pe_wwrite[1][1];
    assign dataout1   = pe_data[0][1];
    assign dataout2   = pe_data[1][1];
    assign activeout1 = pe_active[0][1];
    assign activeout2 = pe_active[1][1];

endmodule

// File: tb/tb_sys_arr_2x2.sv
// Scoreboard bench for sys_arr_2x2: directed cases plus random traffic against a
// cycle-history reference model of the array's dataflow equations.
module tb_sys_arr_2x2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        active = 1'b0;
    logic [15:0] datain = '0;
    logic [15:0] win = '0;
    logic [31:0] sumin = '0;
    logic [1:0]  wwrite = '0;
    logic [15:0] maccout1, maccout2;
    logic [7:0]  wout1, wout2, dataout1, dataout2;
    logic        wwriteout1, wwriteout2, activeout1, activeout2;

    always #5 clk = ~clk;

    sys_arr_2x2 dut (
        .clk(clk), .reset(reset), .active(active), .datain(datain), .win(win),
        .sumin(sumin), .wwrite(wwrite), .maccout1(maccout1), .maccout2(maccout2),
        .wout1(wout1), .wout2(wout2), .wwriteout1(wwriteout1), .wwriteout2(wwriteout2),
        .activeout1(activeout1), .activeout2(activeout2),
        .dataout1(dataout1), .dataout2(dataout2)
    );

    typedef struct {
        logic [15:0] m1;
        logic [15:0] m2;
        logic [17:0] wb;
        logic [17:0] db;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;
    int k = 0;

    // History of inputs and derived state per cycle; cycle n lives at index n+1,
    // indices 0 and 1 stand for the all-zero post-reset history.
    localparam int SZ = 1024;
    int a_h   [SZ];
    int d_h   [2][SZ];
    int s_h   [2][SZ];
    int win_h [2][SZ];
    int ww_h  [2][SZ];
    int w0_h  [2][SZ];
    int w1_h  [2][SZ];
    int sum_h [2][2][SZ];

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want, input int cyc);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%h want=%h", nm, cyc, got, want);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < SZ; i++) begin
            a_h[i] = 0;
            for (int c = 0; c < 2; c++) begin
                d_h[c][i] = 0; s_h[c][i] = 0; win_h[c][i] = 0; ww_h[c][i] = 0;
                w0_h[c][i] = 0; w1_h[c][i] = 0;
                sum_h[0][c][i] = 0; sum_h[1][c][i] = 0;
            end
        end
        k = 0;
    endtask

    function automatic int mac(input int acc, input int x, input int w);
        return (acc + x * w) % 65536;
    endfunction

    // Drive one cycle of inputs and push the outputs expected after the next edge.
    task automatic cycle(input logic act, input logic [15:0] din, input logic [15:0] wv,
                         input logic [31:0] s, input logic [1:0] ww);
        exp_t e;
        int i;
        @(negedge clk);
        active = act; datain = din; win = wv; sumin = s; wwrite = ww;
        k++;
        i = k + 1;
        if (i >= SZ) begin
            $display("FAIL model_overflow cycle=%0d", k);
            $fatal(1, "history overflow");
        end
        a_h[i] = int'(act);
        for (int c = 0; c < 2; c++) begin
            d_h[c][i]   = int'(din[c*8 +: 8]);
            s_h[c][i]   = int'(s[c*16 +: 16]);
            win_h[c][i] = int'(wv[c*8 +: 8]);
            ww_h[c][i]  = int'(ww[c]);
            // Top row loads on this edge; bottom row loads one edge after the top saw the write.
            w0_h[c][i] = (ww_h[c][i] != 0) ? win_h[c][i] : w0_h[c][i-1];
            w1_h[c][i] = (ww_h[c][i-1] != 0) ? win_h[c][i-1] : w1_h[c][i-1];
        end
        sum_h[0][0][i] = (a_h[i] != 0)   ? mac(s_h[0][i], d_h[0][i], w0_h[0][i-1])         : sum_h[0][0][i-1];
        sum_h[1][0][i] = (a_h[i-1] != 0) ? mac(sum_h[0][0][i-1], d_h[1][i], w1_h[0][i-1])  : sum_h[1][0][i-1];
        sum_h[0][1][i] = (a_h[i-1] != 0) ? mac(s_h[1][i], d_h[0][i-1], w0_h[1][i-1])       : sum_h[0][1][i-1];
        sum_h[1][1][i] = (a_h[i-2] != 0) ? mac(sum_h[0][1][i-1], d_h[1][i-1], w1_h[1][i-1]) : sum_h[1][1][i-1];
        e.m1  = 16'(sum_h[1][0][i]);
        e.m2  = 16'(sum_h[1][1][i]);
        e.wb  = {8'(win_h[1][i-1]), 8'(win_h[0][i-1]), 1'(ww_h[1][i-1]), 1'(ww_h[0][i-1])};
        e.db  = {1'(a_h[i-2]), 1'(a_h[i-1]), 8'(d_h[1][i-1]), 8'(d_h[0][i-1])};
        e.cyc = k;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) cycle(1'b0, '0, '0, '0, 2'b00);
    endtask

    task automatic at_edge();
        @(posedge clk);
        #3;
    endtask

    // Assert reset between edges, check outputs clear at once and stay clear.
    task automatic do_reset();
        @(posedge clk);
        #4;
        reset = 1'b1;
        active = 1'b0; datain = '0; win = '0; sumin = '0; wwrite = '0;
        #1;
        chk("reset_async_bus", {maccout1, maccout2, wout1, wout2, dataout1, dataout2}, 64'd0, k);
        chk("reset_async_flags", {60'd0, wwriteout1, wwriteout2, activeout1, activeout2}, 64'd0, k);
        at_edge();
        chk("reset_hold_bus", {maccout1, maccout2, wout1, wout2, dataout1, dataout2}, 64'd0, k);
        chk("reset_hold_flags", {60'd0, wwriteout1, wwriteout2, activeout1, activeout2}, 64'd0, k);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        sb.delete();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (!reset && sb.size() > 0) begin
                e = sb.pop_front();
                chk("maccout1", {48'd0, maccout1}, {48'd0, e.m1}, e.cyc);
                chk("maccout2", {48'd0, maccout2}, {48'd0, e.m2}, e.cyc);
                chk("weight_out", {46'd0, wout2, wout1, wwriteout2, wwriteout1}, {46'd0, e.wb}, e.cyc);
                chk("data_out", {46'd0, activeout2, activeout1, dataout2, dataout1}, {46'd0, e.db}, e.cyc);
                $display("txn cyc=%0d macc1=%h macc2=%h w=%h d=%h", e.cyc, maccout1, maccout2,
                         {wout2, wout1, wwriteout2, wwriteout1}, {activeout2, activeout1, dataout2, dataout1});
            end
        end
    end

    initial begin : stimulus
        model_clear();
        do_reset();

        // Unit weights in all four PEs
        cycle(1'b0, '0, 16'h0101, '0, 2'b11);
        cycle(1'b0, '0, 16'h0101, '0, 2'b11);
        cycle(1'b0, '0, 16'h0000, '0, 2'b00);

        // Unit MAC path with a one-cycle bubble
        cycle(1'b1, 16'h0001, '0, '0, 2'b00);
        cycle(1'b1, 16'h0101, '0, '0, 2'b00);
        at_edge();
        chk("unit_maccout1", {48'd0, maccout1}, 64'd2, k);
        chk("unit_dataout1", {56'd0, dataout1}, 64'd1, k);
        cycle(1'b0, 16'h0101, '0, '0, 2'b00);
        at_edge();
        chk("unit_maccout2", {48'd0, maccout2}, 64'd2, k);
        cycle(1'b1, 16'h0202, '0, '0, 2'b00);
        cycle(1'b1, 16'h0303, '0, '0, 2'b00);
        idle(3);

        // Non-unit operands: col0 weight 3, col1 weight 2
        cycle(1'b0, '0, {8'd2, 8'd3}, '0, 2'b11);
        cycle(1'b0, '0, {8'd2, 8'd3}, '0, 2'b11);
        cycle(1'b0, '0, '0, '0, 2'b00);
        cycle(1'b1, {8'd0, 8'd5}, '0, {16'd10, 16'd4}, 2'b00);
        cycle(1'b0, {8'd7, 8'd0}, '0, {16'd10, 16'd4}, 2'b00);
        idle(2);
        at_edge();
        chk("nonunit_maccout1", {48'd0, maccout1}, 64'd40, k);
        chk("nonunit_maccout2", {48'd0, maccout2}, 64'd34, k);

        // Modulo-2^16 wrap
        cycle(1'b0, '0, 16'hFFFF, '0, 2'b11);
        cycle(1'b0, '0, 16'hFFFF, '0, 2'b11);
        cycle(1'b0, '0, '0, '0, 2'b00);
        cycle(1'b1, 16'h00FF, '0, 32'hFFFF_FFFF, 2'b00);
        cycle(1'b0, 16'hFF00, '0, 32'hFFFF_FFFF, 2'b00);
        idle(2);
        at_edge();
        chk("wrap_maccout1", {48'd0, maccout1}, 64'h0000_0000_0000_FC01, k);
        chk("wrap_maccout2", {48'd0, maccout2}, 64'h0000_0000_0000_FC01, k);

        // Random traffic with a reset in the middle of operation
        for (int r = 0; r < 2; r++) begin
            for (int j = 0; j < 200; j++) begin
                cycle(1'($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom), 32'($urandom),
                      ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00);
            end
            do_reset();
        end
        cycle(1'b1, 16'h0404, '0, '0, 2'b00);
        idle(2);

        for (int j = 0; j < 5 && sb.size() > 0; j++) at_edge();
        if (sb.size() != 0) begin
            bad++;
            total++;
            $display("FAIL scoreboard_drain pending=%0d required=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
